// File: rtl/program_loader_pkg.sv
// Shared definitions for the MiniAlu program loader: state encodings, stream
// field masks and the default program size limit.
package program_loader_pkg;

    localparam logic [2:0] LD_HDR_HI = 3'd0;
    localparam logic [2:0] LD_HDR_LO = 3'd1;
    localparam logic [2:0] LD_DATA   = 3'd2;
    localparam logic [2:0] LD_WRITE  = 3'd3;
    localparam logic [2:0] LD_CHECK  = 3'd4;
    localparam logic [2:0] LD_RUN    = 3'd5;
    localparam logic [2:0] LD_ERROR  = 3'd6;

    // Upper nibble of word byte 0 is reserved and must arrive as zero.
    localparam logic [7:0] LD_RSVD_MASK = 8'hF0;
    localparam int         LD_MAX_WORDS = 256;

    function automatic logic ld_accepting(input logic [2:0] state);
        return (state == LD_HDR_HI) || (state == LD_HDR_LO) ||
               (state == LD_DATA)   || (state == LD_CHECK);
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input, instruction RAM write port and CPU control of the loader.
interface program_loader_if #(
    parameter int ADDR_WIDTH  = 16,
    parameter int INSTR_WIDTH = 28
);
    logic [7:0]             iByte;
    logic                   iByteValid;
    logic                   oByteReady;
    logic                   oWriteEnable;
    logic [ADDR_WIDTH-1:0]  oWriteAddress;
    logic [INSTR_WIDTH-1:0] oInstruction;
    logic                   oCpuReset;
    logic                   oDone;
    logic                   oError;
    logic                   iReload;

    modport master (
        output iByte, iByteValid, iReload,
        input  oByteReady, oWriteEnable, oWriteAddress, oInstruction,
               oCpuReset, oDone, oError
    );

    modport slave (
        input  iByte, iByteValid, iReload,
        output oByteReady, oWriteEnable, oWriteAddress, oInstruction,
               oCpuReset, oDone, oError
    );
endinterface

// File: rtl/program_loader_ffd.sv
// Parameterized-width enable flop with asynchronous active-low reset; holds the
// loader state, instruction shift register and running checksum.
module program_loader_ffd #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            q_o <= RESET_VALUE;
        end else if (enable_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Loads a counted, checksummed big-endian word stream into the MiniAlu
// instruction RAM and holds the CPU in reset until the program verifies.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int INSTR_WIDTH = 28,
    parameter int MAX_WORDS   = LD_MAX_WORDS
) (
    input  logic Clock,
    input  logic Reset,
    program_loader_if.slave bus
);

    localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

    logic [2:0]             state_q, state_d;
    logic [19:0]            shift_q, shift_d;
    logic                   shift_en;
    logic [7:0]             csum_q, csum_d;
    logic                   csum_en;
    logic [15:0]            count_q, count_d;
    logic [15:0]            widx_q, widx_d, widx_inc;
    logic [1:0]             bidx_q, bidx_d;
    logic                   ready_q, ready_d;
    logic                   we_q, we_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   cpu_reset_q, cpu_reset_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;
    logic                   accept;
    logic [15:0]            full_count;

    // ready_q mirrors the accepting states, so accept needs no state decode.
    assign accept     = bus.iByteValid && ready_q;
    assign full_count = {count_q[15:8], bus.iByte};
    assign widx_inc   = widx_q + 16'd1;

    program_loader_ffd #(.WIDTH(3), .RESET_VALUE(LD_HDR_HI)) u_state (
        .Clock(Clock), .Reset(Reset), .enable_i(1'b1), .d_i(state_d), .q_o(state_q)
    );

    program_loader_ffd #(.WIDTH(20)) u_shift (
        .Clock(Clock), .Reset(Reset), .enable_i(shift_en), .d_i(shift_d), .q_o(shift_q)
    );

    program_loader_ffd #(.WIDTH(8)) u_csum (
        .Clock(Clock), .Reset(Reset), .enable_i(csum_en), .d_i(csum_d), .q_o(csum_q)
    );

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        shift_en    = 1'b0;
        shift_d     = {shift_q[11:0], bus.iByte};
        csum_en     = 1'b0;
        csum_d      = csum_q ^ bus.iByte;
        count_d     = count_q;
        widx_d      = widx_q;
        bidx_d      = bidx_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        instr_d     = instr_q;
        cpu_reset_d = cpu_reset_q;
        done_d      = done_q;
        error_d     = error_q;

        case (state_q)
            LD_HDR_HI: begin
                if (accept) begin
                    count_d = {bus.iByte, 8'h00};
                    state_d = LD_HDR_LO;
                end
            end
            LD_HDR_LO: begin
                if (accept) begin
                    count_d = full_count;
                    widx_d  = '0;
                    bidx_d  = '0;
                    if (full_count == 16'd0 || full_count > MAX_N) begin
                        state_d = LD_ERROR;
                        error_d = 1'b1;
                    end else begin
                        state_d = LD_DATA;
                    end
                end
            end
            LD_DATA: begin
                if (accept) begin
                    shift_en = 1'b1;
                    csum_en  = 1'b1;
                    if (bidx_q == 2'd0 && (bus.iByte & LD_RSVD_MASK) != 8'h00) begin
                        state_d = LD_ERROR;
                        error_d = 1'b1;
                    end else if (bidx_q == 2'd3) begin
                        // Only the opcode nibble of byte 0 survives in shift_q[19:16].
                        state_d = LD_WRITE;
                        we_d    = 1'b1;
                        addr_d  = ADDR_WIDTH'(widx_q);
                        instr_d = INSTR_WIDTH'({shift_q, bus.iByte});
                        bidx_d  = 2'd0;
                    end else begin
                        bidx_d = bidx_q + 2'd1;
                    end
                end
            end
            LD_WRITE: begin
                widx_d  = widx_inc;
                state_d = (widx_inc == count_q) ? LD_CHECK : LD_DATA;
            end
            LD_CHECK: begin
                if (accept) begin
                    if (bus.iByte == csum_q) begin
                        state_d     = LD_RUN;
                        cpu_reset_d = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        state_d = LD_ERROR;
                        error_d = 1'b1;
                    end
                end
            end
            LD_RUN, LD_ERROR: begin
                if (bus.iReload) begin
                    state_d     = LD_HDR_HI;
                    count_d     = '0;
                    widx_d      = '0;
                    bidx_d      = '0;
                    csum_en     = 1'b1;
                    csum_d      = 8'h00;
                    cpu_reset_d = 1'b1;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                end
            end
            default: state_d = LD_HDR_HI;
        endcase

        ready_d = ld_accepting(state_d);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            count_q     <= '0;
            widx_q      <= '0;
            bidx_q      <= '0;
            ready_q     <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            instr_q     <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            count_q     <= count_d;
            widx_q      <= widx_d;
            bidx_q      <= bidx_d;
            ready_q     <= ready_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            instr_q     <= instr_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign bus.oByteReady    = ready_q;
    assign bus.oWriteEnable  = we_q;
    assign bus.oWriteAddress = addr_q;
    assign bus.oInstruction  = instr_q;
    assign bus.oCpuReset     = cpu_reset_q;
    assign bus.oDone         = done_q;
    assign bus.oError        = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader: good, corrupt, oversize and
// reserved-nibble streams, throttled input, reload and mid-load reset.
module tb_program_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    program_loader_if #(.ADDR_WIDTH(16), .INSTR_WIDTH(28)) bus ();

    program_loader #(.ADDR_WIDTH(16), .INSTR_WIDTH(28), .MAX_WORDS(256)) dut (
        .Clock(clk),
        .Reset(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Write log captured just after each rising edge.
    logic [15:0] log_addr [64];
    logic [27:0] log_data [64];
    int          wr_count = 0;
    int          ready_in_write = 0;

    always @(posedge clk) begin
        #1;
        if (bus.oWriteEnable === 1'b1) begin
            if (wr_count < 64) begin
                log_addr[wr_count] = bus.oWriteAddress;
                log_data[wr_count] = bus.oInstruction;
            end
            wr_count = wr_count + 1;
            if (bus.oByteReady !== 1'b0) ready_in_write = ready_in_write + 1;
        end
    end

    // The XOR of the eight word bytes 01 00 00 05 02 00 01 00 is 07.
    logic [7:0]  stream_a     [$] = '{8'h00, 8'h02, 8'h01, 8'h00, 8'h00, 8'h05,
                                      8'h02, 8'h00, 8'h01, 8'h00, 8'h07};
    logic [7:0]  stream_a_bad [$] = '{8'h00, 8'h02, 8'h01, 8'h00, 8'h00, 8'h05,
                                      8'h02, 8'h00, 8'h01, 8'h00, 8'h06};
    logic [7:0]  stream_b     [$] = '{8'h00, 8'h03, 8'h0A, 8'hBC, 8'hDE, 8'hF1,
                                      8'h00, 8'h00, 8'h00, 8'h00,
                                      8'h0F, 8'hFF, 8'hFF, 8'hFF, 8'h69};
    logic [7:0]  hdr_zero     [$] = '{8'h00, 8'h00};
    logic [7:0]  hdr_big      [$] = '{8'h01, 8'h01};
    logic [7:0]  rsvd_word    [$] = '{8'h00, 8'h01, 8'h15};
    logic [7:0]  partial_a    [$] = '{8'h00, 8'h02, 8'h01, 8'h00, 8'h00, 8'h05,
                                      8'h02, 8'h00};
    logic [27:0] words_a      [$] = '{28'h1000005, 28'h2000100};
    logic [27:0] words_b      [$] = '{28'hABCDEF1, 28'h0000000, 28'hFFFFFFF};
    logic [27:0] words_none   [$] = '{};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp)
        else begin
            errors = errors + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int budget;
        if (rnd) begin
            for (int i = 0; i < 3 && $urandom_range(0, 1) == 1; i++) @(negedge clk);
        end
        bus.iByte      = b;
        bus.iByteValid = 1'b1;
        budget = 50;
        while (bus.oByteReady !== 1'b1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check("accept_timeout", {31'd0, bus.oByteReady}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.iByteValid = 1'b0;
    endtask

    task automatic send_stream(input logic [7:0] s [$], input bit rnd);
        foreach (s[i]) send_byte(s[i], rnd);
        @(negedge clk);
    endtask

    task automatic expect_writes(input string tag, input int base, input logic [27:0] w [$]);
        check({tag, "_wr_count"}, wr_count - base, w.size());
        foreach (w[i]) begin
            if (base + i < 64 && base + i < wr_count) begin
                check({tag, "_addr"}, {16'd0, log_addr[base + i]}, i);
                check({tag, "_data"}, {4'd0, log_data[base + i]}, {4'd0, w[i]});
            end
        end
    endtask

    task automatic do_reload(input string tag);
        bus.iReload = 1'b1;
        @(negedge clk);
        bus.iReload = 1'b0;
        check({tag, "_ready"},     {31'd0, bus.oByteReady}, 32'd1);
        check({tag, "_done"},      {31'd0, bus.oDone},      32'd0);
        check({tag, "_error"},     {31'd0, bus.oError},     32'd0);
        check({tag, "_cpu_reset"}, {31'd0, bus.oCpuReset},  32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"},     {31'd0, bus.oByteReady},   32'd1);
        check({tag, "_we"},        {31'd0, bus.oWriteEnable}, 32'd0);
        check({tag, "_addr"},      {16'd0, bus.oWriteAddress}, 32'd0);
        check({tag, "_instr"},     {4'd0, bus.oInstruction},  32'd0);
        check({tag, "_cpu_reset"}, {31'd0, bus.oCpuReset},    32'd1);
        check({tag, "_done"},      {31'd0, bus.oDone},        32'd0);
        check({tag, "_error"},     {31'd0, bus.oError},       32'd0);
    endtask

    task automatic hold_valid_idle(input string tag);
        int base;
        base = wr_count;
        bus.iByte      = 8'hAA;
        bus.iByteValid = 1'b1;
        repeat (3) @(negedge clk);
        check({tag, "_ready"},  {31'd0, bus.oByteReady}, 32'd0);
        check({tag, "_writes"}, wr_count - base, 32'd0);
        bus.iByteValid = 1'b0;
    endtask

    initial begin
        int base;
        bus.iByte      = 8'h00;
        bus.iByteValid = 1'b0;
        bus.iReload    = 1'b0;

        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Good two-word program, stepped to observe strobe and release timing.
        base = wr_count;
        for (int i = 0; i < 5; i++) send_byte(stream_a[i], 1'b0);
        check("a_no_early_we", {31'd0, bus.oWriteEnable}, 32'd0);
        send_byte(stream_a[5], 1'b0);
        check("a_we_after_byte3", {31'd0, bus.oWriteEnable},   32'd1);
        check("a_we_addr",        {16'd0, bus.oWriteAddress},  32'd0);
        check("a_we_instr",       {4'd0, bus.oInstruction},    32'h1000005);
        check("a_ready_in_write", {31'd0, bus.oByteReady},     32'd0);
        for (int i = 6; i < 10; i++) send_byte(stream_a[i], 1'b0);
        @(negedge clk);
        check("a_cpu_reset_before_csum", {31'd0, bus.oCpuReset}, 32'd1);
        send_byte(stream_a[10], 1'b0);
        check("a_cpu_reset_released", {31'd0, bus.oCpuReset}, 32'd0);
        check("a_done",               {31'd0, bus.oDone},     32'd1);
        check("a_error",              {31'd0, bus.oError},    32'd0);
        expect_writes("a", base, words_a);
        hold_valid_idle("run_hold");
        check("run_hold_done", {31'd0, bus.oDone}, 32'd1);
        do_reload("reload_run");

        // Corrupt checksum: both words still written, CPU never released.
        base = wr_count;
        send_stream(stream_a_bad, 1'b0);
        check("bad_error",     {31'd0, bus.oError},    32'd1);
        check("bad_cpu_reset", {31'd0, bus.oCpuReset}, 32'd1);
        check("bad_done",      {31'd0, bus.oDone},     32'd0);
        expect_writes("bad", base, words_a);
        do_reload("reload_err");
        base = wr_count;
        send_stream(stream_a, 1'b0);
        check("a2_done", {31'd0, bus.oDone}, 32'd1);
        expect_writes("a2", base, words_a);
        do_reload("reload_a2");

        // Count boundaries: zero and MAX_WORDS+1.
        base = wr_count;
        send_stream(hdr_zero, 1'b0);
        check("zero_error", {31'd0, bus.oError}, 32'd1);
        expect_writes("zero", base, words_none);
        do_reload("reload_zero");
        base = wr_count;
        send_stream(hdr_big, 1'b0);
        check("big_error", {31'd0, bus.oError}, 32'd1);
        expect_writes("big", base, words_none);
        do_reload("reload_big");

        // Reserved nibble set in the first word byte.
        base = wr_count;
        for (int i = 0; i < 3; i++) send_byte(rsvd_word[i], 1'b0);
        check("rsvd_error",     {31'd0, bus.oError},     32'd1);
        check("rsvd_cpu_reset", {31'd0, bus.oCpuReset},  32'd1);
        hold_valid_idle("err_hold");
        expect_writes("rsvd", base, words_none);
        do_reload("reload_rsvd");

        // Three-word program, back-to-back then throttled.
        base = wr_count;
        send_stream(stream_b, 1'b0);
        check("b_done", {31'd0, bus.oDone}, 32'd1);
        expect_writes("b", base, words_b);
        do_reload("reload_b");
        base = wr_count;
        send_stream(stream_b, 1'b1);
        check("b_rnd_done", {31'd0, bus.oDone}, 32'd1);
        expect_writes("b_rnd", base, words_b);
        do_reload("reload_b_rnd");
        base = wr_count;
        send_stream(stream_a, 1'b1);
        check("a_rnd_done", {31'd0, bus.oDone}, 32'd1);
        expect_writes("a_rnd", base, words_a);
        do_reload("reload_a_rnd");

        // Asynchronous reset pulse in the middle of the second word.
        send_stream(partial_a, 1'b0);
        check("mid_instr_loaded", {4'd0, bus.oInstruction}, 32'h1000005);
        #2 rst_n = 1'b0;
        #1 check_reset_values("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        base = wr_count;
        send_stream(stream_a, 1'b0);
        check("post_reset_done",      {31'd0, bus.oDone},     32'd1);
        check("post_reset_cpu_reset", {31'd0, bus.oCpuReset}, 32'd0);
        expect_writes("post_reset", base, words_a);

        check("ready_low_in_write", ready_in_write, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
